// File: rtl/uart_boot_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_boot_loader_if
// Description : UART byte input and RAM write / boot status bundle for the
//               boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_boot_loader_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_wen;
    logic              cpu_hold;
    logic              boot_done;
    logic              boot_err;
    logic [15:0]       words_loaded;

    modport master (
        output rx_data, rx_valid,
        input  ram_addr, ram_wdata, ram_wen, cpu_hold, boot_done, boot_err, words_loaded
    );

    modport slave (
        input  rx_data, rx_valid,
        output ram_addr, ram_wdata, ram_wen, cpu_hold, boot_done, boot_err, words_loaded
    );
endinterface
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_boot_loader
// Description : Loads a UART program image (SYNC, LEN, LEN words) into RAM and
//               holds the core in reset until done. Define BOOT_CHECKSUM_EN
//               to require a trailing XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_boot_loader #(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 1024,
    parameter logic [7:0]        SYNC_BYTE = 8'hA5
) (
    input  wire logic        clk,
    input  wire logic        rst,
    uart_boot_loader_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_LAST   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    logic [2:0]        r_state,     w_state;
    logic [15:0]       r_len,       w_len;
    logic [1:0]        r_idx,       w_idx;
    logic [31:0]       r_word,      w_word;
    logic [ADDR_W-1:0] r_ram_addr,  w_ram_addr;
    logic [31:0]       r_ram_wdata, w_ram_wdata;
    logic              r_ram_wen,   w_ram_wen;
    logic              r_cpu_hold,  w_cpu_hold;
    logic              r_boot_done, w_boot_done;
    logic              r_boot_err,  w_boot_err;
    logic [15:0]       r_words,     w_words;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        r_csum,      w_csum;
`endif

    logic        w_sync;
    logic [15:0] w_len_full;

    assign w_sync     = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
    assign w_len_full = {bus.rx_data, r_len[7:0]};

    always_comb begin
        w_state     = r_state;
        w_len       = r_len;
        w_idx       = r_idx;
        w_word      = r_word;
        w_ram_addr  = r_ram_addr;
        w_ram_wdata = r_ram_wdata;
        w_ram_wen   = 1'b0;
        w_cpu_hold  = r_cpu_hold;
        w_boot_done = r_boot_done;
        w_boot_err  = r_boot_err;
        w_words     = r_words;
`ifdef BOOT_CHECKSUM_EN
        w_csum      = r_csum;
`endif
        case (r_state)
            S_IDLE, S_DONE, S_ERR, S_LAST: begin
                if (w_sync) begin
                    w_state     = S_LEN_LO;
                    w_words     = '0;
                    w_boot_done = 1'b0;
                    w_boot_err  = 1'b0;
                    w_cpu_hold  = 1'b1;
`ifdef BOOT_CHECKSUM_EN
                    w_csum      = '0;
`endif
                end else if (r_state == S_LAST) begin
                    // Release the core only once the final write pulse is over.
                    w_state     = S_DONE;
                    w_cpu_hold  = 1'b0;
                    w_boot_done = 1'b1;
                end
            end
            S_LEN_LO: begin
                if (bus.rx_valid) begin
                    w_len[7:0] = bus.rx_data;
                    w_state    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (bus.rx_valid) begin
                    w_len = w_len_full;
                    w_idx = '0;
                    if (w_len_full > 16'(MAX_WORDS)) begin
                        w_state    = S_ERR;
                        w_boot_err = 1'b1;
                        w_cpu_hold = 1'b1;
                    end else if (w_len_full == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                        w_state     = S_CSUM;
`else
                        w_state     = S_DONE;
                        w_cpu_hold  = 1'b0;
                        w_boot_done = 1'b1;
`endif
                    end else begin
                        w_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    w_word[{r_idx, 3'b000} +: 8] = bus.rx_data;
                    w_idx                        = r_idx + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                    w_csum = r_csum ^ bus.rx_data;
`endif
                    if (r_idx == 2'd3) begin
                        w_ram_wdata = w_word;
                        w_ram_addr  = BASE_ADDR + ADDR_W'({r_words, 2'b00});
                        w_ram_wen   = 1'b1;
                        w_words     = r_words + 16'd1;
                        if ((r_words + 16'd1) == r_len) begin
`ifdef BOOT_CHECKSUM_EN
                            w_state = S_CSUM;
`else
                            w_state = S_LAST;
`endif
                        end
                    end
                end
            end
            S_CSUM: begin
`ifdef BOOT_CHECKSUM_EN
                if (bus.rx_valid) begin
                    if (bus.rx_data == r_csum) begin
                        w_state     = S_DONE;
                        w_cpu_hold  = 1'b0;
                        w_boot_done = 1'b1;
                    end else begin
                        w_state    = S_ERR;
                        w_boot_err = 1'b1;
                        w_cpu_hold = 1'b1;
                    end
                end
`else
                w_state = S_IDLE;
`endif
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            r_ram_addr  <= BASE_ADDR;
            r_ram_wdata <= '0;
            r_ram_wen   <= 1'b0;
            r_cpu_hold  <= 1'b1;
            r_boot_done <= 1'b0;
            r_boot_err  <= 1'b0;
            r_words     <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_state     <= w_state;
            r_len       <= w_len;
            r_idx       <= w_idx;
            r_word      <= w_word;
            r_ram_addr  <= w_ram_addr;
            r_ram_wdata <= w_ram_wdata;
            r_ram_wen   <= w_ram_wen;
            r_cpu_hold  <= w_cpu_hold;
            r_boot_done <= w_boot_done;
            r_boot_err  <= w_boot_err;
            r_words     <= w_words;
`ifdef BOOT_CHECKSUM_EN
            r_csum      <= w_csum;
`endif
        end
    end

    assign bus.ram_addr     = r_ram_addr;
    assign bus.ram_wdata    = r_ram_wdata;
    assign bus.ram_wen      = r_ram_wen;
    assign bus.cpu_hold     = r_cpu_hold;
    assign bus.boot_done    = r_boot_done;
    assign bus.boot_err     = r_boot_err;
    assign bus.words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_boot_loader
// Description : Self-checking bench for uart_boot_loader: frame-level model
//               plus directed frames with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_boot_loader;

    localparam int         ADDR_W    = 12;
    localparam int         BASE_ADDR = 0;
    localparam int         MAX_WORDS = 1024;
    localparam logic [7:0] SYNC      = 8'hA5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_boot_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (ADDR_W'(BASE_ADDR)),
        .MAX_WORDS (MAX_WORDS),
        .SYNC_BYTE (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    bit          m_started = 0;
    bit          m_active, m_pend;
    logic [7:0]  m_frame[$];
    int          m_len, m_n, m_d;
    logic [7:0]  m_x;
    logic              m_wen;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic              m_hold, m_done, m_err;
    logic [15:0]       m_words;

    always @(posedge clk) begin
        m_started = 1;
        m_wen     = 1'b0;
        if (rst) begin
            m_active = 0; m_pend = 0; m_frame.delete();
            m_addr = ADDR_W'(BASE_ADDR); m_wdata = '0;
            m_hold = 1'b1; m_done = 1'b0; m_err = 1'b0; m_words = '0;
        end else begin
            if (m_pend) begin
                m_pend = 0;
                if (!(bus.rx_valid && bus.rx_data == SYNC)) begin
                    m_done = 1'b1; m_hold = 1'b0;
                end
            end
            if (bus.rx_valid) begin
                if (!m_active) begin
                    if (bus.rx_data == SYNC) begin
                        m_active = 1; m_frame.delete();
                        m_words = '0; m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1;
                    end
                end else begin
                    m_frame.push_back(bus.rx_data);
                    m_n = m_frame.size();
                    if (m_n == 2) begin
                        m_len = int'(m_frame[0]) + 256 * int'(m_frame[1]);
                        if (m_len > MAX_WORDS) begin
                            m_err = 1'b1; m_hold = 1'b1; m_active = 0;
                        end else if (m_len == 0) begin
`ifndef BOOT_CHECKSUM_EN
                            m_done = 1'b1; m_hold = 1'b0; m_active = 0;
`endif
                        end
                    end else if (m_n > 2) begin
                        m_d = m_n - 3;
                        if (m_d < 4 * m_len) begin
                            if (m_d % 4 == 3) begin
                                m_wen   = 1'b1;
                                m_addr  = ADDR_W'(BASE_ADDR + 4 * (m_d / 4));
                                m_wdata = {m_frame[m_n-1], m_frame[m_n-2], m_frame[m_n-3], m_frame[m_n-4]};
                                m_words = 16'(m_d / 4 + 1);
`ifndef BOOT_CHECKSUM_EN
                                if (m_d == 4 * m_len - 1) begin
                                    m_pend = 1; m_active = 0;
                                end
`endif
                            end
                        end else begin
                            m_x = 8'h00;
                            for (int i = 2; i < m_n - 1; i++) m_x ^= m_frame[i];
                            if (m_x == bus.rx_data) begin
                                m_done = 1'b1; m_hold = 1'b0;
                            end else begin
                                m_err = 1'b1; m_hold = 1'b1;
                            end
                            m_active = 0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare and write log ----------------
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    always @(negedge clk) begin
        if (m_started) begin
            check("ram_wen",      32'(bus.ram_wen),      32'(m_wen));
            check("ram_addr",     32'(bus.ram_addr),     32'(m_addr));
            check("ram_wdata",    bus.ram_wdata,         m_wdata);
            check("cpu_hold",     32'(bus.cpu_hold),     32'(m_hold));
            check("boot_done",    32'(bus.boot_done),    32'(m_done));
            check("boot_err",     32'(bus.boot_err),     32'(m_err));
            check("words_loaded", 32'(bus.words_loaded), 32'(m_words));
            if (bus.ram_wen) begin
                log_addr.push_back(32'(bus.ram_addr));
                log_data.push_back(bus.ram_wdata);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0]  tx[$];
    logic [31:0] fw[$];

    task automatic add_frame();
        logic [7:0] cs;
        logic [7:0] b;
        int         n;
        cs = 8'h00;
        n  = fw.size();
        tx.push_back(SYNC);
        tx.push_back(8'(n));
        tx.push_back(8'(n >> 8));
        foreach (fw[i]) begin
            for (int k = 0; k < 4; k++) begin
                b = fw[i][8*k +: 8];
                tx.push_back(b);
                cs ^= b;
            end
        end
`ifdef BOOT_CHECKSUM_EN
        tx.push_back(cs);
`endif
    endtask

    task automatic send(input bit gap);
        foreach (tx[i]) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = tx[i];
            @(negedge clk);
            if (gap) begin
                bus.rx_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.rx_valid = 1'b0;
        tx.delete();
    endtask

    task automatic check_two_words(input string tag);
        check({tag, "_nwrites"}, 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            check({tag, "_addr0"}, log_addr[0], 32'h000);
            check({tag, "_data0"}, log_data[0], 32'h0000_0013);
            check({tag, "_addr1"}, log_addr[1], 32'h004);
            check({tag, "_data1"}, log_data[1], 32'h0010_0093);
        end
        check({tag, "_done"},  32'(bus.boot_done),    32'd1);
        check({tag, "_hold"},  32'(bus.cpu_hold),     32'd0);
        check({tag, "_words"}, 32'(bus.words_loaded), 32'd2);
    endtask

    initial begin
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_hold",  32'(bus.cpu_hold),     32'd1);
        check("rst_wen",   32'(bus.ram_wen),      32'd0);
        check("rst_done",  32'(bus.boot_done),    32'd0);
        check("rst_err",   32'(bus.boot_err),     32'd0);
        check("rst_words", 32'(bus.words_loaded), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Idle noise is ignored
        tx = '{8'h00, 8'h13};
        send(1'b1);
        repeat (3) @(negedge clk);
        check("idle_done",    32'(bus.boot_done),  32'd0);
        check("idle_hold",    32'(bus.cpu_hold),   32'd1);
        check("idle_nwrites", 32'(log_addr.size()), 32'd0);

        // Two-word image, spaced bytes
        fw = '{32'h0000_0013, 32'h0010_0093};
        log_addr.delete(); log_data.delete();
        add_frame(); send(1'b1);
        repeat (4) @(negedge clk);
        check_two_words("gap");

        // Same image, back-to-back bytes
        log_addr.delete(); log_data.delete();
        add_frame(); send(1'b0);
        repeat (4) @(negedge clk);
        check_two_words("b2b");

        // LEN = 1025 rejected, then a valid frame recovers
        log_addr.delete(); log_data.delete();
        tx = '{SYNC, 8'h01, 8'h04};
        send(1'b0);
        repeat (3) @(negedge clk);
        check("len_err",     32'(bus.boot_err),   32'd1);
        check("len_hold",    32'(bus.cpu_hold),   32'd1);
        check("len_nwrites", 32'(log_addr.size()), 32'd0);
        add_frame(); send(1'b0);
        repeat (4) @(negedge clk);
        check_two_words("recover");

`ifdef BOOT_CHECKSUM_EN
        log_addr.delete(); log_data.delete();
        tx = '{SYNC, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        send(1'b0);
        repeat (3) @(negedge clk);
        check("csum_bad_nwrites", 32'(log_addr.size()), 32'd1);
        if (log_data.size() == 1) check("csum_bad_data", log_data[0], 32'h4433_2211);
        check("csum_bad_err",  32'(bus.boot_err),  32'd1);
        check("csum_bad_hold", 32'(bus.cpu_hold),  32'd1);
        tx = '{SYNC, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send(1'b0);
        repeat (3) @(negedge clk);
        check("csum_ok_done", 32'(bus.boot_done), 32'd1);
        check("csum_ok_err",  32'(bus.boot_err),  32'd0);
`endif

        // Next frame's SYNC lands in the final write cycle of the previous one
        log_addr.delete(); log_data.delete();
        fw = '{32'hDEAD_BEEF};
        add_frame();
        fw = '{32'h0000_0013, 32'h0010_0093};
        add_frame();
        send(1'b0);
        repeat (4) @(negedge clk);
        check("chain_nwrites", 32'(log_addr.size()), 32'd3);
        if (log_addr.size() == 3) begin
            check("chain_data0", log_data[0], 32'hDEAD_BEEF);
            check("chain_addr1", log_addr[1], 32'h000);
            check("chain_addr2", log_addr[2], 32'h004);
        end
        check("chain_done", 32'(bus.boot_done), 32'd1);

        // Reset after two data bytes, then reload from base
        tx = '{SYNC, 8'h02, 8'h00, 8'h13, 8'h00};
        send(1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_addr",  32'(bus.ram_addr),     32'h000);
        check("mid_rst_hold",  32'(bus.cpu_hold),     32'd1);
        check("mid_rst_words", 32'(bus.words_loaded), 32'd0);
        check("mid_rst_wdata", bus.ram_wdata,         32'd0);
        log_addr.delete(); log_data.delete();
        add_frame(); send(1'b0);
        repeat (4) @(negedge clk);
        check_two_words("after_rst");

        // Empty image
        fw.delete();
        add_frame(); send(1'b0);
        repeat (3) @(negedge clk);
        check("len0_done",  32'(bus.boot_done),    32'd1);
        check("len0_words", 32'(bus.words_loaded), 32'd0);

        // Largest accepted image fills the whole address space
        log_addr.delete(); log_data.delete();
        fw.delete();
        for (int i = 0; i < MAX_WORDS; i++) fw.push_back(32'(i) ^ 32'hA5A5_0000);
        add_frame(); send(1'b0);
        repeat (4) @(negedge clk);
        check("max_words", 32'(bus.words_loaded), 32'd1024);
        check("max_done",  32'(bus.boot_done),    32'd1);
        check("max_nwrites", 32'(log_addr.size()), 32'd1024);
        if (log_addr.size() == 1024) begin
            check("max_last_addr", log_addr[1023], 32'hFFC);
            check("max_last_data", log_data[1023], 32'hA5A5_03FF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
